// File: rtl/udma_tx_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : udma_tx_req_arbiter
//  Purpose  : Shares one uDMA TX linear channel read port between N_REQ
//             peripheral TX requesters. Requests are arbitrated round-robin,
//             one grant per cycle, and an in-order ID FIFO steers each read
//             response back to the requester that issued it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_REQ      number of requesters (2..16)
//    DATA_WIDTH width of the TX data bus
//    MAX_OUTST  depth of the outstanding-grant ID FIFO (power of two, >= 2)
//
//  Ports
//    sys_clk_i       in   1            system clock, rising edge
//    rstn_i          in   1            asynchronous active-low reset
//    req_i           in   N_REQ        per-requester read request
//    datasize_i      in   2*N_REQ      per-requester datasize, slice k = [2k+1:2k]
//    gnt_o           out  N_REQ        one-hot grant (same cycle as mst_gnt_i)
//    data_o          out  DATA_WIDTH   response data broadcast to all requesters
//    valid_o         out  N_REQ        per-requester response valid
//    ready_i         in   N_REQ        per-requester response ready
//    mst_req_o       out  1            request to the uDMA TX channel
//    mst_datasize_o  out  2            datasize of the selected requester
//    mst_gnt_i       in   1            grant from the uDMA TX channel
//    mst_data_i      in   DATA_WIDTH   response data from the channel
//    mst_valid_i     in   1            response valid from the channel
//    mst_ready_o     out  1            response ready to the channel
//
//  Optional build macro UDMA_TX_ARB_ERR_EN adds:
//    err_o           out  1            sticky flag: response seen with no
//                                      outstanding grant
//    err_clr_i       in   1            clears err_o (set wins over clear)
// ============================================================================
module udma_tx_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                    sys_clk_i,
  input  logic                    rstn_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [2*N_REQ-1:0]      datasize_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [N_REQ-1:0]        valid_o,
  input  logic [N_REQ-1:0]        ready_i,
`ifdef UDMA_TX_ARB_ERR_EN
  output logic                    err_o,
  input  logic                    err_clr_i,
`endif
  output logic                    mst_req_o,
  output logic [1:0]              mst_datasize_o,
  input  logic                    mst_gnt_i,
  input  logic [DATA_WIDTH-1:0]   mst_data_i,
  input  logic                    mst_valid_i,
  output logic                    mst_ready_o
);

  // --------------------------------------------------------------------------
  // Local widths
  // --------------------------------------------------------------------------
  localparam int RR_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  localparam logic [RR_W:0]    N_REQ_EXT = (RR_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTST);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  fifo_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic            any_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic [RR_W-1:0] sel;
  logic [RR_W:0]   scan_idx;
  logic            sel_found;
  logic [RR_W-1:0] rr_next;
  logic [RR_W:0]   rr_inc;
  logic [RR_W-1:0] head;
  logic            push;
  logic            pop;

  assign any_req    = |req_i;
  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // --------------------------------------------------------------------------
  // Round-robin selection: first asserted request starting at rr_ptr.
  // rr_ptr + i is below 2*N_REQ, so one conditional subtract gives the modulo
  // without a divider, also for non power-of-two N_REQ.
  // --------------------------------------------------------------------------
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (RR_W+1)'(i);
      if (scan_idx >= N_REQ_EXT) begin
        scan_idx = scan_idx - N_REQ_EXT;
      end
      if (!sel_found && req_i[scan_idx[RR_W-1:0]]) begin
        sel_found = 1'b1;
        sel       = scan_idx[RR_W-1:0];
      end
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_comb begin
    rr_inc  = {1'b0, sel} + (RR_W+1)'(1);
    rr_next = rr_inc[RR_W-1:0];
    if (rr_inc == N_REQ_EXT) begin
      rr_next = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Request path: a full ID FIFO blocks new requests so every response always
  // has an owner recorded.
  // --------------------------------------------------------------------------
  assign mst_req_o = any_req & ~fifo_full;
  assign push      = mst_req_o & mst_gnt_i;

  always_comb begin
    mst_datasize_o = 2'b00;
    if (any_req) begin
      mst_datasize_o = datasize_i[{sel, 1'b0} +: 2];
    end
  end

  always_comb begin
    gnt_o = '0;
    if (push) begin
      gnt_o[sel] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Response path: pure passthrough steered by the FIFO head. With the FIFO
  // empty the channel is always accepted so a stray beat cannot lock it up.
  // --------------------------------------------------------------------------
  assign data_o = mst_data_i;

  always_comb begin
    valid_o     = '0;
    mst_ready_o = 1'b1;
    if (!fifo_empty) begin
      valid_o[head] = mst_valid_i;
      mst_ready_o   = ready_i[head];
    end
  end

  assign pop = ~fifo_empty & mst_valid_i & mst_ready_o;

  // --------------------------------------------------------------------------
  // Arbiter and FIFO control state
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        rr_ptr <= rr_next;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ID storage. A push into an empty FIFO is only visible at the head from
  // the next cycle, so a same-cycle response is treated as unowned.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr] <= sel;
    end
  end

  // --------------------------------------------------------------------------
  // Optional protocol-error flag
  // --------------------------------------------------------------------------
`ifdef UDMA_TX_ARB_ERR_EN
  logic proto_err;

  assign proto_err = fifo_empty & mst_valid_i;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_o <= 1'b0;
    end else if (proto_err) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire
